fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue_if.sv | 23 ++
 rtl/fq_fifo.sv | 103 ++++++++++
 rtl/fetch_queue.sv | 138 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fq_state_e;

    localparam int          DEFAULT_DEPTH    = 4;
    localparam logic [29:0] DEFAULT_RESET_PC = 30'h0000_0C00;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    function automatic logic [29:0] pc_inc(input logic [29:0] pc);
        return pc + 30'd1;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Memory-side, redirect and IF/ID-side signals of the fetch queue.
interface fetch_queue_if;
    logic        im_req;
    logic [29:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        redir;
    logic [29:0] redir_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [29:0] out_pc;
    logic        out_ready;

    modport master (
        output im_req, im_addr, out_valid, out_instr, out_pc,
        input  im_ack, im_rdata, redir, redir_pc, out_ready
    );

    modport slave (
        input  im_req, im_addr, out_valid, out_instr, out_pc,
        output im_ack, im_rdata, redir, redir_pc, out_ready
    );
endinterface

// File: rtl/fq_fifo.sv
// Circular instruction buffer with a registered head entry so the
// IF/ID side sees flop outputs; flush empties it in one cycle.
module fq_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  fq_entry_t     push_data_i,
    input  logic          pop_i,
    output logic [CW-1:0] count_o,
    output logic          valid_o,
    output fq_entry_t     head_o
);

    fq_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              valid_q, valid_d;
    fq_entry_t         head_data_q, head_data_d;
    logic [AW-1:0]     head_nxt_s;
    logic [CW-1:0]     rem_s;
    logic              pop_ok_s;

    assign pop_ok_s   = pop_i && valid_q;
    assign head_nxt_s = head_q + AW'(1);

    // Next pointers, occupancy and the entry that will sit at the head.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        valid_d     = valid_q;
        head_data_d = head_data_q;
        rem_s       = count_q - CW'(pop_ok_s);
        if (flush_i) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            valid_d     = 1'b0;
            head_data_d = '0;
        end else begin
            if (pop_ok_s) begin
                head_d = head_nxt_s;
            end else begin
                head_d = head_q;
            end
            if (push_i) begin
                tail_d = tail_q + AW'(1);
            end else begin
                tail_d = tail_q;
            end
            count_d = rem_s + CW'(push_i);
            valid_d = (count_d != '0);
            // An empty buffer after the pop means the pushed word becomes the head.
            if (rem_s == '0) begin
                if (push_i) begin
                    head_data_d = push_data_i;
                end else begin
                    head_data_d = '0;
                end
            end else if (pop_ok_s) begin
                head_data_d = mem_q[head_nxt_s];
            end else begin
                head_data_d = head_data_q;
            end
        end
    end

    // Storage array and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            head_data_q <= '0;
        end else begin
            if (!flush_i && push_i) begin
                mem_q[tail_q] <= push_data_i;
            end
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            head_data_q <= head_data_d;
        end
    end

    assign count_o = count_q;
    assign valid_o = valid_q;
    assign head_o  = head_data_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: one outstanding memory read, redirect flush
// with stale-response drain, buffered words presented to IF/ID.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [29:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fq_state_e     state_q, state_d;
    logic [29:0]   fetch_pc_q, fetch_pc_d;
    logic          im_req_q, im_req_d;
    logic [29:0]   im_addr_q, im_addr_d;

    logic [CW-1:0] count_s;
    logic [CW-1:0] count_after_s;
    logic          space_s;
    logic          push_s;
    logic          pop_s;
    logic          head_valid_s;
    fq_entry_t     head_s;
    fq_entry_t     push_entry_s;
    logic [29:0]   pc_next_s;

    assign push_s        = (state_q == ST_FETCH) && bus.im_ack && !bus.redir;
    assign pop_s         = head_valid_s && bus.out_ready;
    assign count_after_s = count_s + CW'(push_s) - CW'(pop_s);
    assign space_s       = (count_after_s < CW'(DEPTH));
    assign pc_next_s     = pc_inc(fetch_pc_q);
    assign push_entry_s  = '{pc: fetch_pc_q, instr: bus.im_rdata};

    fq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (bus.redir),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .count_o     (count_s),
        .valid_o     (head_valid_s),
        .head_o      (head_s)
    );

    // Request FSM: fetch_pc always names the word of the live request.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        im_req_d   = im_req_q;
        im_addr_d  = im_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.redir) begin
                    fetch_pc_d = bus.redir_pc;
                    im_req_d   = 1'b1;
                    im_addr_d  = bus.redir_pc;
                    state_d    = ST_FETCH;
                end else if (space_s) begin
                    im_req_d   = 1'b1;
                    im_addr_d  = fetch_pc_q;
                    state_d    = ST_FETCH;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.redir) begin
                    fetch_pc_d = bus.redir_pc;
                    if (bus.im_ack) begin
                        im_req_d  = 1'b1;
                        im_addr_d = bus.redir_pc;
                        state_d   = ST_FETCH;
                    end else begin
                        state_d   = ST_DRAIN;
                    end
                end else if (bus.im_ack) begin
                    fetch_pc_d = pc_next_s;
                    if (space_s) begin
                        im_req_d  = 1'b1;
                        im_addr_d = pc_next_s;
                        state_d   = ST_FETCH;
                    end else begin
                        im_req_d  = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // The outstanding response is stale; only its completion matters.
                if (bus.redir) begin
                    fetch_pc_d = bus.redir_pc;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                if (bus.im_ack) begin
                    im_req_d  = 1'b1;
                    im_addr_d = bus.redir ? bus.redir_pc : fetch_pc_q;
                    state_d   = ST_FETCH;
                end else begin
                    state_d   = ST_DRAIN;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                im_req_d = 1'b0;
            end
        endcase
    end

    // Control state and request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            im_req_q   <= 1'b0;
            im_addr_q  <= 30'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            im_req_q   <= im_req_d;
            im_addr_q  <= im_addr_d;
        end
    end

    assign bus.im_req    = im_req_q;
    assign bus.im_addr   = im_addr_q;
    assign bus.out_valid = head_valid_s;
    assign bus.out_instr = head_s.instr;
    assign bus.out_pc    = head_s.pc;

endmodule
